// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage issue controller.
// Optional feature macro: ALU_MULDIV_EN (enables MUL and DIV opcodes).
package alu_pkg;

    localparam int DATA_W = 16;

    // Instruction opcodes
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_LDI = 4'b1000;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_DIV = 3'b101;

    // Instruction field positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEC,
        S_EXEC,
        S_WB
    } state_t;

    typedef struct packed {
        logic       legal;  // opcode may execute
        logic       ldi;    // immediate load, bypasses the ALU
        logic [2:0] ctrl;   // ALUControl for ALU opcodes
    } dec_t;

    // Classify an opcode; anything not listed here is illegal.
    function automatic dec_t decode_op(input logic [3:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_ADD: begin d.legal = 1'b1; d.ctrl = ALU_ADD; end
            OP_SUB: begin d.legal = 1'b1; d.ctrl = ALU_SUB; end
            OP_AND: begin d.legal = 1'b1; d.ctrl = ALU_AND; end
            OP_OR:  begin d.legal = 1'b1; d.ctrl = ALU_OR;  end
`ifdef ALU_MULDIV_EN
            OP_MUL: begin d.legal = 1'b1; d.ctrl = ALU_MUL; end
            OP_DIV: begin d.legal = 1'b1; d.ctrl = ALU_DIV; end
`endif
            OP_LDI: begin d.legal = 1'b1; d.ldi = 1'b1; end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU driven by alu_issue_ctrl.
// Results are truncated to DATA_W bits; division is unsigned and
// yields 0 for a zero divisor (the controller never issues that case).
module alu #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        ALUControl,
    output logic [DATA_W-1:0] Result
);

    logic [2*DATA_W-1:0] prod;

    assign prod = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};

    // Select the operation result
    always_comb begin
        Result = '0;
        case (ALUControl)
            3'b000: Result = A + B;
            3'b001: Result = A - B;
            3'b010: Result = A & B;
            3'b011: Result = A | B;
            3'b100: Result = prod[DATA_W-1:0];
            3'b101: Result = (B == '0) ? '0 : (A / B);
            default: Result = '0;
        endcase
    end

endmodule

// File: rtl/alu_regfile.sv
// Register file: one synchronous write port, two combinational operand
// read ports and a combinational debug read port, cleared on reset.
module alu_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] rf [NREG];

    // Clear every entry on reset, otherwise perform the single write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (we) begin
            rf[waddr] <= wdata;
        end
    end

    assign rdata1   = rf[raddr1];
    assign rdata2   = rf[raddr2];
    assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: accepts one instruction at a time, reads
// operands, drives the external ALU and writes the result back.
// Optional feature macro: ALU_MULDIV_EN (MUL/DIV legal when defined).
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              err,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    import alu_pkg::*;

    state_t            state;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] res_q;
    logic              fault;

    dec_t              dec;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              rf_we;
    logic [DATA_W-1:0] wb_data;

    assign dec         = decode_op(instr_q[OP_MSB:OP_LSB]);
    assign instr_ready = (state == S_IDLE);

    // Only a non-faulted instruction in WB touches the register file
    assign rf_we   = (state == S_WB) && !fault;
    assign wb_data = dec.ldi ? {{(DATA_W-8){1'b0}}, instr_q[IMM_MSB:IMM_LSB]} : res_q;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (instr_q[RD_MSB:RD_LSB]),
        .wdata    (wb_data),
        .raddr1   (instr_q[RS1_MSB:RS1_LSB]),
        .rdata1   (rs1_data),
        .raddr2   (instr_q[RS2_MSB:RS2_LSB]),
        .rdata2   (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Instruction sequencer with registered ALU drive and retire pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            instr_q  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            res_q    <= '0;
            fault    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        fault   <= 1'b0;
                        state   <= S_DEC;
                    end
                end
                S_DEC: begin
                    if (dec.ldi) begin
                        state <= S_WB;
                    end else if (!dec.legal) begin
                        fault <= 1'b1;
                        state <= S_WB;
                    end else if ((dec.ctrl == ALU_DIV) && (rs2_data == '0)) begin
                        // Divide by zero faults before the ALU ever sees a 0 divisor
                        fault <= 1'b1;
                        state <= S_WB;
                    end else begin
                        alu_a    <= rs1_data;
                        alu_b    <= rs2_data;
                        alu_ctrl <= dec.ctrl;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q <= alu_result;
                    state <= S_WB;
                end
                S_WB: begin
                    done  <= 1'b1;
                    err   <= fault;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl driving the real alu.
// Build with or without +define+ALU_MULDIV_EN.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [15:0] alu_result;
    logic        done;
    logic        err;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [31:0]  cyc;
        logic         err;
        logic [15:0]  a;
        logic [15:0]  b;
        logic [2:0]   ctrl;
        logic [255:0] rf;
    } exp_t;

    exp_t q[$];

    // Bench-side view of architectural state
    logic [255:0] mrf;
    logic [15:0]  m_a;
    logic [15:0]  m_b;
    logic [2:0]   m_ctrl;

    alu_issue_ctrl #(.DATA_W(16), .NREG(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .done        (done),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    alu #(.DATA_W(16)) u_alu (
        .A          (alu_a),
        .B          (alu_b),
        .ALUControl (alu_ctrl),
        .Result     (alu_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mrf    = '0;
        m_a    = '0;
        m_b    = '0;
        m_ctrl = '0;
    endtask

    // Offer one instruction; leaves instr_valid high after acceptance.
    // lat: cycles from accept edge to done; e_val/e_ctrl are hand-computed.
    task automatic issue(input logic [15:0] ins, input int lat, input logic e_err,
                         input logic [15:0] e_val, input logic [2:0] e_ctrl);
        int   n;
        int   rd;
        int   rs1;
        int   rs2;
        exp_t e;
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 256'(instr_ready), 256'(1));
        end else begin
            rd  = int'(ins[11:8]);
            rs1 = int'(ins[7:4]);
            rs2 = int'(ins[3:0]);
            if (lat == 3) begin
                m_a    = mrf[rs1*16 +: 16];
                m_b    = mrf[rs2*16 +: 16];
                m_ctrl = e_ctrl;
            end
            if (!e_err) mrf[rd*16 +: 16] = e_val;
            e.cyc  = 32'(cyc + 1 + lat);
            e.err  = e_err;
            e.a    = m_a;
            e.b    = m_b;
            e.ctrl = m_ctrl;
            e.rf   = mrf;
            q.push_back(e);
            $display("issue instr=%04h accept_edge=%0d expect_done=%0d err=%0b", ins, cyc + 1, e.cyc, e_err);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 256'(q.size()), 256'(0));
    endtask

    // Monitor: on every retire pop the expectation and compare outputs and the whole register file
    initial begin
        exp_t         e;
        logic [255:0] got;
        dbg_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst && err && !done) chk("err_without_done", 256'(err), 256'(0));
            if (!rst && done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 256'(done), 256'(0));
                end else begin
                    e = q.pop_front();
                    for (int i = 0; i < 16; i++) begin
                        dbg_addr = 4'(i);
                        #0.1;
                        got[i*16 +: 16] = dbg_data;
                    end
                    $display("retire edge=%0d err=%0b ctrl=%03b a=%04h b=%04h", cyc, err, alu_ctrl, alu_a, alu_b);
                    chk("done_cycle", 256'(cyc), 256'(e.cyc));
                    chk("err", 256'(err), 256'(e.err));
                    chk("alu_a", 256'(alu_a), 256'(e.a));
                    chk("alu_b", 256'(alu_b), 256'(e.b));
                    chk("alu_ctrl", 256'(alu_ctrl), 256'(e.ctrl));
                    chk("regfile", got, e.rf);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        model_reset();
        #2;
        chk("rst_ready", 256'(instr_ready), 256'(1));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_alu_a", 256'(alu_a), 256'(0));
        chk("rst_alu_b", 256'(alu_b), 256'(0));
        chk("rst_alu_ctrl", 256'(alu_ctrl), 256'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic ADD
        issue(16'h810B, 2, 1'b0, 16'd11, 3'b000);     // LDI r1,11
        issue(16'h8203, 2, 1'b0, 16'd3,  3'b000);     // LDI r2,3
        issue(16'h0312, 3, 1'b0, 16'd14, 3'b000);     // ADD r3,r1,r2 -> 14
        // SUB / AND / OR
        issue(16'h810A, 2, 1'b0, 16'd10, 3'b000);     // LDI r1,10
        issue(16'h1412, 3, 1'b0, 16'd7,  3'b001);     // SUB r4 -> 7
        issue(16'h810C, 2, 1'b0, 16'd12, 3'b000);     // LDI r1,12
        issue(16'h820A, 2, 1'b0, 16'd10, 3'b000);     // LDI r2,10
        issue(16'h2512, 3, 1'b0, 16'd8,  3'b010);     // AND r5 -> 8
        issue(16'h3612, 3, 1'b0, 16'd14, 3'b011);     // OR r6 -> 14
        issue(16'h0766, 3, 1'b0, 16'd28, 3'b000);     // ADD r7,r6,r6 -> 28 (dependent)
`ifdef ALU_MULDIV_EN
        issue(16'h4812, 3, 1'b0, 16'd120, 3'b100);    // MUL r8 = 12*10
        issue(16'h5982, 3, 1'b0, 16'd12,  3'b101);    // DIV r9 = 120/10
        issue(16'h8A96, 2, 1'b0, 16'd150, 3'b000);    // LDI r10,150
        issue(16'h0AAA, 3, 1'b0, 16'd300, 3'b000);    // ADD r10 = 300
        issue(16'h4BAA, 3, 1'b0, 16'h5F90, 3'b100);   // MUL r11 = 300*300 truncated
        issue(16'h5510, 2, 1'b1, 16'd0,   3'b000);    // DIV r5,r1,r0 -> fault
`else
        issue(16'h4812, 2, 1'b1, 16'd0, 3'b000);      // MUL illegal
        issue(16'h5510, 2, 1'b1, 16'd0, 3'b000);      // DIV illegal
`endif
        issue(16'hF123, 2, 1'b1, 16'd0, 3'b000);      // opcode 1111 illegal
        issue(16'h6123, 2, 1'b1, 16'd0, 3'b000);      // opcode 0110 illegal
        issue(16'h8055, 2, 1'b0, 16'h0055, 3'b000);   // LDI r0,0x55 (r0 writable)
        // instr_valid held high with the same instruction: one accept per IDLE
        issue(16'h8CAB, 2, 1'b0, 16'h00AB, 3'b000);
        issue(16'h8CAB, 2, 1'b0, 16'h00AB, 3'b000);
        go_idle();
        drain();

        // Reset in the middle of an ADD
        @(negedge clk);
        instr       = 16'h0312;
        instr_valid = 1'b1;
        @(posedge clk);               // accept edge k
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);               // k+1
        @(posedge clk);               // k+2
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_done", 256'(done), 256'(0));
        chk("midrst_err", 256'(err), 256'(0));
        chk("midrst_alu_a", 256'(alu_a), 256'(0));
        chk("midrst_alu_b", 256'(alu_b), 256'(0));
        chk("midrst_alu_ctrl", 256'(alu_ctrl), 256'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", 256'(instr_ready), 256'(1));
        chk("midrst_no_done", 256'(done), 256'(0));
        issue(16'h8705, 2, 1'b0, 16'd5,  3'b000);     // LDI r7,5 (rest of rf must be 0)
        issue(16'h0877, 3, 1'b0, 16'd10, 3'b000);     // ADD r8,r7,r7 -> 10
        go_idle();
        drain();
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
